minitb_ahb_cmd_master: RTL and testbench

MINITB_AHB_CMD_MASTER -- requirements
Module: minitb_ahb_cmd_master

---
 rtl/minitb_ahb_cmd_master_if.sv | 40 ++++
 rtl/minitb_ahb_cmd_master.sv | 171 +++++++++++++++++
 tb/tb_minitb_ahb_cmd_master.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/minitb_ahb_cmd_master_if.sv
// Bundles the command, AHB-Lite and response signals of the command master.
// The master modport is the design side; the slave modport is the environment side.
interface minitb_ahb_cmd_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [2:0]            cmd_size;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [1:0]            htrans;
  logic [ADDR_WIDTH-1:0] haddr;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hready;
  logic                  hresp;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [2:0]            outstanding;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  hrdata, hready, hresp, rsp_ready,
    output cmd_ready, htrans, haddr, hwrite, hsize, hwdata,
    output rsp_valid, rsp_rdata, rsp_err, outstanding
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output hrdata, hready, hresp, rsp_ready,
    input  cmd_ready, htrans, haddr, hwrite, hsize, hwdata,
    input  rsp_valid, rsp_rdata, rsp_err, outstanding
  );
endinterface

// File: rtl/minitb_ahb_cmd_master.sv
// AHB-Lite command master: queued commands go out as single NONSEQ transfers,
// responses come back in command order through a response FIFO.
//
// data-phase state | meaning
// D_IDLE           | no transfer in data phase
// D_ACTIVE         | transfer in data phase, waiting for hready
// D_ERR            | second ERROR cycle; address phase cancelled (htrans=IDLE)
module minitb_ahb_cmd_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int RSP_DEPTH  = 4
) (
  input logic                     hclk,
  input logic                     hresetn,
  minitb_ahb_cmd_master_if.master bus
);
  localparam int CMD_AW   = $clog2(CMD_DEPTH);
  localparam int RSP_AW   = $clog2(RSP_DEPTH);
  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam int CMD_W    = 1 + ADDR_WIDTH + 3 + DATA_WIDTH;
  localparam int RSP_W    = 1 + DATA_WIDTH;

  typedef enum logic [1:0] {D_IDLE, D_ACTIVE, D_ERR} d_state_t;
  d_state_t d_state, d_state_nxt;

  logic                  ready_q;
  logic [CMD_W-1:0]      cmd_mem [CMD_DEPTH];
  logic [CMD_AW-1:0]     cmd_wr_ptr, cmd_rd_ptr;
  logic [CMD_AW:0]       cmd_cnt;
  logic [RSP_W-1:0]      rsp_mem [RSP_DEPTH];
  logic [RSP_AW-1:0]     rsp_wr_ptr, rsp_rd_ptr;
  logic [RSP_AW:0]       rsp_cnt;

  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [2:0]            head_size;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic                  head_legal;

  logic                  a_valid, a_write;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [2:0]            a_size;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  d_write;
  logic [DATA_WIDTH-1:0] d_wdata;

  logic                  cmd_push, cmd_pop, issue_pop, rej_pop;
  logic                  rsp_push, rsp_pop;
  logic [RSP_W-1:0]      rsp_push_data;
  logic                  a_live, a_done, d_done, rsp_room;
  logic [2:0]            outstanding_w;

  assign {head_write, head_addr, head_size, head_wdata} = cmd_mem[cmd_rd_ptr];

  always_comb begin
    head_legal = 1'b0;
    if (head_size <= 3'(MAX_SIZE))
      head_legal = (head_addr & ~({ADDR_WIDTH{1'b1}} << head_size)) == '0;
  end

  assign a_live        = a_valid && (d_state != D_ERR);
  assign a_done        = a_live && bus.hready;
  assign d_done        = (d_state != D_IDLE) && bus.hready;
  assign outstanding_w = {2'b00, a_valid} + {2'b00, d_state != D_IDLE};
  // Reserve a response slot for everything already in flight before popping.
  assign rsp_room      = (int'(rsp_cnt) + int'(outstanding_w)) < RSP_DEPTH;

  assign cmd_push  = bus.cmd_valid && bus.cmd_ready;
  assign issue_pop = (cmd_cnt != '0) && head_legal && (!a_valid || a_done) && rsp_room;
  // Illegal commands wait for the pipe to drain so their error stays in order.
  assign rej_pop   = (cmd_cnt != '0) && !head_legal && (outstanding_w == 3'd0) &&
                     (rsp_cnt != (RSP_AW+1)'(RSP_DEPTH));
  assign cmd_pop   = issue_pop || rej_pop;

  assign rsp_push = d_done || rej_pop;
  assign rsp_pop  = bus.rsp_valid && bus.rsp_ready;

  always_comb begin
    rsp_push_data = {1'b1, {DATA_WIDTH{1'b0}}};
    if (d_done) begin
      if ((d_state == D_ERR) || bus.hresp)
        rsp_push_data = {1'b1, {DATA_WIDTH{1'b0}}};
      else
        rsp_push_data = {1'b0, d_write ? {DATA_WIDTH{1'b0}} : bus.hrdata};
    end
  end

  always_ff @(posedge hclk) begin
    if (cmd_push)
      cmd_mem[cmd_wr_ptr] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_size, bus.cmd_wdata};
    if (rsp_push)
      rsp_mem[rsp_wr_ptr] <= rsp_push_data;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ready_q    <= 1'b0;
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_cnt    <= '0;
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_cnt    <= '0;
    end else begin
      ready_q <= 1'b1;
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
      if (cmd_push && !cmd_pop)      cmd_cnt <= cmd_cnt + 1'b1;
      else if (!cmd_push && cmd_pop) cmd_cnt <= cmd_cnt - 1'b1;
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
      if (rsp_push && !rsp_pop)      rsp_cnt <= rsp_cnt + 1'b1;
      else if (!rsp_push && rsp_pop) rsp_cnt <= rsp_cnt - 1'b1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      a_valid <= 1'b0;
      a_write <= 1'b0;
      a_addr  <= '0;
      a_size  <= '0;
      a_wdata <= '0;
      d_write <= 1'b0;
      d_wdata <= '0;
    end else begin
      if (issue_pop) begin
        a_valid <= 1'b1;
        a_write <= head_write;
        a_addr  <= head_addr;
        a_size  <= head_size;
        a_wdata <= head_wdata;
      end else if (a_done) begin
        a_valid <= 1'b0;
      end
      if (a_done) begin
        d_write <= a_write;
        d_wdata <= a_wdata;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) d_state <= D_IDLE;
    else          d_state <= d_state_nxt;
  end

  always_comb begin
    d_state_nxt = d_state;
    case (d_state)
      D_IDLE:   if (a_done) d_state_nxt = D_ACTIVE;
      D_ACTIVE: begin
        if (bus.hready)     d_state_nxt = a_done ? D_ACTIVE : D_IDLE;
        else if (bus.hresp) d_state_nxt = D_ERR;
      end
      D_ERR:    if (bus.hready) d_state_nxt = D_IDLE;
      default:  d_state_nxt = D_IDLE;
    endcase
  end

  assign bus.cmd_ready   = ready_q && (cmd_cnt != (CMD_AW+1)'(CMD_DEPTH));
  assign bus.htrans      = a_live ? 2'b10 : 2'b00;
  assign bus.haddr       = a_live ? a_addr : '0;
  assign bus.hwrite      = a_live && a_write;
  assign bus.hsize       = a_live ? a_size : 3'd0;
  assign bus.hwdata      = ((d_state != D_IDLE) && d_write) ? d_wdata : '0;
  assign bus.rsp_valid   = rsp_cnt != '0;
  assign {bus.rsp_err, bus.rsp_rdata} = bus.rsp_valid ? rsp_mem[rsp_rd_ptr] : '0;
  assign bus.outstanding = outstanding_w;
endmodule

// File: tb/tb_minitb_ahb_cmd_master.sv
// Bench for minitb_ahb_cmd_master: behavioural AHB slave, response scoreboard,
// a table of single commands and hand sequences for the multi-cycle cases.
module tb_minitb_ahb_cmd_master;
  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  minitb_ahb_cmd_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus();

  minitb_ahb_cmd_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CMD_DEPTH(4), .RSP_DEPTH(4)) dut (
    .hclk(hclk),
    .hresetn(hresetn),
    .bus(bus)
  );

  typedef struct { logic err; logic [31:0] rdata; } rsp_t;
  typedef struct {
    logic w; logic [7:0] a; logic [2:0] s; logic [31:0] d;
    logic e_err; logic [31:0] e_rd;
  } vec_t;

  rsp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // slave configuration and observations
  logic       err_en = 1'b0;
  logic [7:0] err_addr = 8'h00;
  logic [7:0] wait_addr = 8'hFF;
  int         wait_n = 0;
  int         issued = 0;
  int         max_out = 0;
  int         done_cnt [256];
  int         nonseq_cycles [256];
  logic       err2_seen = 1'b0;
  logic [1:0] err2_htrans = 2'b00;
  int         rsp_seen = 0;

  logic       dp_valid = 1'b0;
  logic [7:0] dp_addr = 8'h00;
  int         wait_left = 0;
  int         err_st = 0;
  logic       s_hready = 1'b1;
  logic [1:0] s_htrans = 2'b00;
  logic [7:0] s_haddr = 8'h00;

  function automatic logic [31:0] model(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Slave: retire the cycle that just ended, then drive hready/hresp/hrdata for the next.
  always @(negedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_valid = 1'b0; err_st = 0; wait_left = 0;
      s_hready = 1'b1; s_htrans = 2'b00;
      bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = 32'h0;
    end else begin
      if (s_hready) begin
        dp_valid = 1'b0;
        err_st = 0;
        if (s_htrans == 2'b10) begin
          dp_valid = 1'b1;
          dp_addr = s_haddr;
          done_cnt[s_haddr]++;
          issued++;
          wait_left = (s_haddr == wait_addr) ? wait_n : 0;
          err_st = (err_en && s_haddr == err_addr) ? 1 : 0;
        end
      end else if (err_st == 1) begin
        err_st = 2;
      end
      bus.hready = 1'b1;
      bus.hresp  = 1'b0;
      bus.hrdata = dp_valid ? model(dp_addr) : 32'h0;
      if (dp_valid) begin
        if (err_st == 1) begin
          bus.hready = 1'b0; bus.hresp = 1'b1;
        end else if (err_st == 2) begin
          bus.hresp = 1'b1; err2_seen = 1'b1; err2_htrans = bus.htrans;
        end else if (wait_left > 0) begin
          bus.hready = 1'b0; wait_left--;
        end
      end
      s_hready = bus.hready;
      s_htrans = bus.htrans;
      s_haddr  = bus.haddr;
      if (bus.htrans == 2'b10) nonseq_cycles[bus.haddr]++;
      if (int'(bus.outstanding) > max_out) max_out = int'(bus.outstanding);
    end
  end

  // Scoreboard: compare each response as it is consumed.
  rsp_t head;
  always @(negedge hclk) begin
    if (hresetn && bus.rsp_valid) rsp_seen++;
    if (hresetn && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got err=%0b rdata=%0h, expected no response", bus.rsp_err, bus.rsp_rdata);
      end else begin
        head = exp_q.pop_front();
        check("rsp_err", 64'(bus.rsp_err), 64'(head.err));
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(head.rdata));
      end
    end
  end

  task automatic send(input logic w, input logic [7:0] a, input logic [2:0] s,
                      input logic [31:0] d, input logic e_err, input logic [31:0] e_rd);
    int g = 0;
    rsp_t r;
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a;
    bus.cmd_size = s; bus.cmd_wdata = d;
    while (!bus.cmd_ready && g < 100) begin @(negedge hclk); g++; end
    if (g >= 100) begin
      n_checks++;
      $display("FAIL send_timeout: cmd_ready stayed 0 for addr %0h, required 1", a);
    end
    @(posedge hclk); #1;
    bus.cmd_valid = 1'b0;
    r.err = e_err; r.rdata = e_rd;
    exp_q.push_back(r);
  endtask

  task automatic drain(input string name);
    int g = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid || bus.outstanding != 3'd0) && g < 300) begin
      @(negedge hclk); g++;
    end
    check({name, "_drain_pending"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_nonseq(input string name);
    int g = 0;
    while (bus.htrans != 2'b10 && g < 20) begin @(negedge hclk); g++; end
    check({name, "_nonseq_seen"}, 64'(g < 20), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  vec_t vecs[8];

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h00;
    bus.cmd_size = 3'd0; bus.cmd_wdata = 32'h0; bus.rsp_ready = 1'b1;
    foreach (done_cnt[i]) begin done_cnt[i] = 0; nonseq_cycles[i] = 0; end

    vecs[0] = '{1'b1, 8'h04, 3'd2, 32'h11223344, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 8'h04, 3'd2, 32'h0, 1'b0, model(8'h04)};
    vecs[2] = '{1'b1, 8'h06, 3'd1, 32'h0000BEEF, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 8'h07, 3'd0, 32'h0, 1'b0, model(8'h07)};
    vecs[4] = '{1'b0, 8'h06, 3'd2, 32'h0, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 8'h08, 3'd3, 32'h12345678, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 8'h0A, 3'd1, 32'h0, 1'b0, model(8'h0A)};
    vecs[7] = '{1'b1, 8'h03, 3'd1, 32'h0000AAAA, 1'b1, 32'h0};

    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check("rst_htrans", 64'(bus.htrans), 64'(0));
    check("rst_haddr_hwrite_hsize", 64'({bus.haddr, bus.hwrite, bus.hsize}), 64'(0));
    check("rst_hwdata", 64'(bus.hwdata), 64'(0));
    check("rst_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 64'(0));
    check("rst_outstanding", 64'(bus.outstanding), 64'(0));
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    hresetn = 1'b1;
    #1 check("cmd_ready_before_edge", 64'(bus.cmd_ready), 64'(0));
    @(posedge hclk); #1;
    check("cmd_ready_after_edge", 64'(bus.cmd_ready), 64'(1));

    // table of single commands, legal and illegal mixed
    issued = 0;
    for (int i = 0; i < 8; i++)
      send(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, vecs[i].e_err, vecs[i].e_rd);
    drain("table");
    check("table_issued", 64'(issued), 64'(5));

    // single write, zero wait
    issued = 0;
    send(1'b1, 8'h10, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0);
    wait_nonseq("wr");
    check("wr_addr_fields", 64'({bus.haddr, bus.hwrite, bus.hsize}), 64'({8'h10, 1'b1, 3'd2}));
    @(negedge hclk);
    check("wr_nonseq_one_cycle", 64'(bus.htrans), 64'(0));
    check("wr_hwdata", 64'(bus.hwdata), 64'(32'hDEADBEEF));
    drain("wr");
    check("wr_issued", 64'(issued), 64'(1));

    // two reads, two wait states on the first
    wait_addr = 8'h20; wait_n = 2; max_out = 0; nonseq_cycles[8'h24] = 0;
    send(1'b0, 8'h20, 3'd2, 32'h0, 1'b0, model(8'h20));
    send(1'b0, 8'h24, 3'd2, 32'h0, 1'b0, model(8'h24));
    drain("wait");
    check("wait_addr24_cycles", 64'(nonseq_cycles[8'h24]), 64'(3));
    check("wait_max_outstanding", 64'(max_out), 64'(2));
    wait_addr = 8'hFF; wait_n = 0;

    // ERROR on first read cancels and reissues the pending second
    err_en = 1'b1; err_addr = 8'h30; err2_seen = 1'b0; done_cnt[8'h34] = 0;
    send(1'b0, 8'h30, 3'd2, 32'h0, 1'b1, 32'h0);
    send(1'b0, 8'h34, 3'd2, 32'h0, 1'b0, model(8'h34));
    drain("err");
    check("err_second_cycle_seen", 64'(err2_seen), 64'(1));
    check("err_second_cycle_htrans", 64'(err2_htrans), 64'(0));
    check("err_reissue_count", 64'(done_cnt[8'h34]), 64'(1));
    err_en = 1'b0;

    // misaligned write never reaches the bus
    issued = 0;
    send(1'b1, 8'h01, 3'd2, 32'h55AA55AA, 1'b1, 32'h0);
    drain("misalign");
    check("misalign_issued", 64'(issued), 64'(0));

    // response back-pressure limits issue to RSP_DEPTH
    bus.rsp_ready = 1'b0; issued = 0;
    for (int i = 0; i < 5; i++)
      send(1'b0, 8'(8'h40 + 4 * i), 3'd2, 32'h0, 1'b0, model(8'(8'h40 + 4 * i)));
    repeat (20) @(negedge hclk);
    check("bp_issued_four", 64'(issued), 64'(4));
    check("bp_outstanding", 64'(bus.outstanding), 64'(0));
    @(posedge hclk); #1 bus.rsp_ready = 1'b1;
    @(posedge hclk); #1 bus.rsp_ready = 1'b0;
    repeat (10) @(negedge hclk);
    check("bp_fifth_issued", 64'(issued), 64'(5));
    bus.rsp_ready = 1'b1;
    drain("bp");

    // reset during the data phase of a write
    send(1'b1, 8'h60, 3'd2, 32'hCAFEF00D, 1'b0, 32'h0);
    wait_nonseq("rst");
    @(posedge hclk); #1;
    check("rst_mid_hwdata_before", 64'(bus.hwdata), 64'(32'hCAFEF00D));
    #1 hresetn = 1'b0;
    #1;
    check("rst_mid_bus", 64'({bus.htrans, bus.haddr, bus.hwrite, bus.hsize}), 64'(0));
    check("rst_mid_hwdata", 64'(bus.hwdata), 64'(0));
    check("rst_mid_status", 64'({bus.rsp_valid, bus.outstanding, bus.cmd_ready}), 64'(0));
    exp_q.delete();
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    rsp_seen = 0; issued = 0;
    repeat (15) @(negedge hclk);
    check("rst_mid_no_rsp", 64'(rsp_seen), 64'(0));
    check("rst_mid_no_issue", 64'(issued), 64'(0));
    check("rst_mid_ready", 64'(bus.cmd_ready), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
